key_event_fifo: RTL and testbench

Converts the per-key single-cycle press pulses from the keypad pulse generator into a queue of 4-bit key codes for the CPU-side peripheral bus. Simultaneous or back-to-back presses are held in a pending register and serialised lowest-index first into a small first-word-fall-through FIFO. The block sits directly downstream of the keypad pulse generator and upstream of the bus register interface.

---
 rtl/key_event_fifo.sv | 112 +++++++++++
 tb/tb_key_event_fifo.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_fifo
//  Description : Collects single-cycle key press pulses into a pending
//                register and serialises them, lowest key index first, into
//                a first-word-fall-through FIFO of 4-bit key codes. Presses
//                that arrive for an already-pending key set a sticky
//                overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_event_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              pulse,
    input  logic                     rd_en,
    output logic [3:0]               rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int                 c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0]      c_FULL_CNT = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW:0]      c_CNT_ONE  = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0]    c_PTR_ONE  = c_AW'(1);

    logic [15:0]     r_pend;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_overflow;
    logic [3:0]      r_mem [DEPTH];

    logic [15:0]     w_lowest;
    logic [15:0]     w_grant;
    logic [3:0]      w_code;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_lost;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_FULL_CNT);
    assign w_pop    = rd_en && !w_empty;
    // A push at full is allowed when the same edge frees a slot.
    assign w_push   = (r_pend != 16'h0000) && (!w_full || w_pop);
    // Two's-complement trick isolates the lowest pending key.
    assign w_lowest = r_pend & (~r_pend + 16'h0001);
    assign w_grant  = w_push ? w_lowest : 16'h0000;
    // A press is lost only if its key is pending and not leaving this cycle.
    assign w_lost   = |(pulse & r_pend & ~w_grant);

    // Binary-encode the one-hot grant into the key code written to the FIFO.
    always_comb begin
        w_code = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (w_lowest[i]) begin
                w_code = 4'(i);
            end
        end
    end

    // Pending register, pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend     <= 16'h0000;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_grant) | pulse;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            // A new loss takes priority over a clear in the same cycle.
            if (w_lost) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Code storage; contents are never visible while empty, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_code;
        end
    end

    assign rd_data  = w_empty ? 4'h0 : r_mem[r_rd_ptr];
    assign empty    = w_empty;
    assign full     = w_full;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_key_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_event_fifo
//  Description : Self-checking bench for key_event_fifo. A cycle model keeps
//                the expected pending set and a queue of expected codes; the
//                DUT outputs are compared against it after every edge, plus
//                directed checks on the key scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_fifo;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pulse;
    logic        rd_en;
    logic [3:0]  rd_data;
    logic        empty;
    logic        full;
    logic [3:0]  count;
    logic        overflow;
    logic        ovf_clr;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [15:0] m_pend = 16'h0000;
    logic [3:0]  m_q[$];
    logic        m_ovf = 1'b0;

    key_event_fifo #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .pulse    (pulse),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one edge using the inputs the DUT samples.
    task automatic model_step();
        logic        pop;
        logic        push;
        logic [15:0] grant;
        logic [3:0]  code;
        logic        lost;
        if (rst) begin
            m_pend = 16'h0000;
            m_q.delete();
            m_ovf  = 1'b0;
        end else begin
            pop   = rd_en && (m_q.size() != 0);
            push  = (m_pend != 16'h0000) && ((m_q.size() < DEPTH) || pop);
            grant = 16'h0000;
            code  = 4'h0;
            if (push) begin
                for (int i = 15; i >= 0; i--) begin
                    if (m_pend[i]) begin
                        grant = 16'h0001 << i;
                        code  = 4'(i);
                    end
                end
            end
            lost = |(pulse & m_pend & ~grant);
            if (pop)  void'(m_q.pop_front());
            if (push) m_q.push_back(code);
            m_pend = (m_pend & ~grant) | pulse;
            if (lost)         m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
        end
    endtask

    task automatic check_all();
        logic [3:0] head;
        head = (m_q.size() != 0) ? m_q[0] : 4'h0;
        chk("model_count",    count,    m_q.size());
        chk("model_empty",    empty,    m_q.size() == 0);
        chk("model_full",     full,     m_q.size() == DEPTH);
        chk("model_overflow", overflow, m_ovf);
        chk("model_rd_data",  rd_data,  head);
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        pulse = 16'h0000; rd_en = 1'b0; ovf_clr = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pop_expect(input string tag, input logic [3:0] exp);
        chk(tag, rd_data, exp);
        chk({tag, "_nonempty"}, empty, 1'b0);
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pulse = 16'h0000; rd_en = 1'b0; ovf_clr = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_count", count, 4'd0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_rd_data", rd_data, 4'h0);

        // Single key: visible two edges after the pulse.
        pulse = 16'h0020;
        cycle();
        pulse = 16'h0000;
        chk("single_still_empty", empty, 1'b1);
        cycle();
        chk("single_empty", empty, 1'b0);
        chk("single_code", rd_data, 4'h5);
        chk("single_count", count, 4'd1);
        pop_expect("single_pop", 4'h5);
        chk("single_after_empty", empty, 1'b1);
        chk("single_after_data", rd_data, 4'h0);

        // Simultaneous presses serialise lowest index first.
        pulse = 16'h8101;
        cycle();
        pulse = 16'h0000;
        cycle(); chk("simul_count1", count, 4'd1);
        cycle(); chk("simul_count2", count, 4'd2);
        cycle(); chk("simul_count3", count, 4'd3);
        idle(2);
        chk("simul_count_end", count, 4'd3);
        pop_expect("simul_c0", 4'h0);
        pop_expect("simul_c8", 4'h8);
        pop_expect("simul_cF", 4'hF);
        chk("simul_drained", empty, 1'b1);

        // Fill and backpressure: keys 8 and 9 wait in the pending set.
        pulse = 16'h03FF;
        cycle();
        idle(8);
        chk("fill_full", full, 1'b1);
        chk("fill_count", count, 4'd8);
        idle(3);
        chk("fill_hold_full", full, 1'b1);
        chk("fill_no_ovf", overflow, 1'b0);
        for (int i = 0; i < 10; i++) pop_expect($sformatf("fill_read%0d", i), 4'(i));
        chk("fill_drained", empty, 1'b1);

        // Lost event: second press of a pending key while full.
        pulse = 16'h00FF;
        cycle();
        idle(8);
        chk("lost_full", full, 1'b1);
        pulse = 16'h0100;
        cycle();
        pulse = 16'h0000;
        chk("lost_first_no_ovf", overflow, 1'b0);
        pulse = 16'h0100;
        cycle();
        pulse = 16'h0000;
        chk("lost_second_ovf", overflow, 1'b1);
        pulse = 16'h0100; ovf_clr = 1'b1;
        cycle();
        pulse = 16'h0000; ovf_clr = 1'b0;
        chk("lost_set_wins", overflow, 1'b1);
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        chk("lost_cleared", overflow, 1'b0);
        for (int i = 0; i < 9; i++) pop_expect($sformatf("lost_read%0d", i), 4'(i));
        chk("lost_single_8", empty, 1'b1);
        idle(2);
        chk("lost_no_second_8", empty, 1'b1);

        // Push/pop at full with pointer wrap; low keys keep P nonzero.
        pulse = 16'hFFFF;
        cycle();
        idle(8);
        chk("wrap_full", full, 1'b1);
        for (int k = 0; k < 20; k++) begin
            pulse = 16'h0001 << (k % 8);
            rd_en = 1'b1;
            cycle();
            chk($sformatf("wrap_count%0d", k), count, 4'd8);
        end
        rd_en = 1'b0; pulse = 16'h0000;
        chk("wrap_no_ovf", overflow, 1'b0);
        rd_en = 1'b1;
        for (int k = 0; k < 16; k++) cycle();
        rd_en = 1'b0;
        chk("wrap_drained", empty, 1'b1);

        // Reset mid-drain with P=FFFF and five entries queued.
        pulse = 16'h001F;
        cycle();
        idle(5);
        chk("mid_count5", count, 4'd5);
        pulse = 16'hFFFF;
        cycle();
        pulse = 16'h0000;
        rst = 1'b1; rd_en = 1'b1;
        cycle();
        rst = 1'b0; rd_en = 1'b0;
        chk("mid_rst_empty", empty, 1'b1);
        chk("mid_rst_count", count, 4'd0);
        chk("mid_rst_ovf", overflow, 1'b0);
        chk("mid_rst_data", rd_data, 4'h0);
        idle(4);
        chk("mid_no_stale", empty, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
